// File: rtl/pcie_ring_buffer_pkg.sv
// Shared types for the PCIe packet ring buffer: flit format, reader states,
// and the output-buffer entry.
package pcie_ring_buffer_pkg;

    localparam int PDU_AWIDTH = 10;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
    } flit_lite_t;

    typedef enum logic {
        RB_IDLE,
        RB_STREAM
    } rb_state_t;

    typedef struct packed {
        flit_lite_t flit;
        logic       sop;
        logic       eop;
    } rb_ent_t;

endpackage

// File: rtl/unified_fifo.sv
// Generic show-ahead FIFO; only the single-clock build (DUAL_CLOCK=0) is implemented.
// The other build parks the outputs as permanently full and empty.
module unified_fifo #(
    parameter int BITS_PER_SYMBOL = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int DUAL_CLOCK      = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic [BITS_PER_SYMBOL-1:0]    wr_data_i,
    input  logic                          rd_en_i,
    output logic [BITS_PER_SYMBOL-1:0]    rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int CW = IW + 1;

    generate
        if (DUAL_CLOCK == 0) begin : g_sc
            logic [BITS_PER_SYMBOL-1:0] mem_q [FIFO_DEPTH];
            logic [IW-1:0]              wr_idx_q, rd_idx_q;
            logic [CW-1:0]              cnt_q;
            logic                       push, pop;

            assign push = wr_en_i && (cnt_q != CW'(FIFO_DEPTH));
            assign pop  = rd_en_i && (cnt_q != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_idx_q <= '0;
                    rd_idx_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (push)
                        wr_idx_q <= (wr_idx_q == IW'(FIFO_DEPTH - 1)) ? '0 : wr_idx_q + 1'b1;
                    if (pop)
                        rd_idx_q <= (rd_idx_q == IW'(FIFO_DEPTH - 1)) ? '0 : rd_idx_q + 1'b1;
                    cnt_q <= cnt_q + CW'(push) - CW'(pop);
                end
            end

            always_ff @(posedge clk) begin
                if (push)
                    mem_q[wr_idx_q] <= wr_data_i;
            end

            assign rd_data_o = mem_q[rd_idx_q];
            assign full_o    = (cnt_q == CW'(FIFO_DEPTH));
            assign empty_o   = (cnt_q == '0);
            assign count_o   = cnt_q;
        end else begin : g_unsupported
            assign rd_data_o = '0;
            assign full_o    = 1'b1;
            assign empty_o   = 1'b1;
            assign count_o   = '0;
        end
    endgenerate

endmodule

// File: rtl/pcie_ring_buffer.sv
// Host-side PCIe ring buffer: producer writes flits and commits blocks, a reader
// drains committed blocks in order as a sop/eop-framed valid/ready stream.
module pcie_ring_buffer
    import pcie_ring_buffer_pkg::*;
#(
    parameter int RB_AWIDTH       = PDU_AWIDTH,
    parameter int AF_SLACK        = 64,
    parameter int SIZE_FIFO_DEPTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  flit_lite_t           pcie_rb_wr_data,
    input  logic [RB_AWIDTH-1:0] pcie_rb_wr_addr,
    input  logic                 pcie_rb_wr_en,
    output logic [RB_AWIDTH-1:0] pcie_rb_wr_base_addr,
    output logic                 pcie_rb_almost_full,
    input  logic                 pcie_rb_update_valid,
    input  logic [RB_AWIDTH-1:0] pcie_rb_update_size,
    output flit_lite_t           rb_out_data,
    output logic                 rb_out_sop,
    output logic                 rb_out_eop,
    output logic                 rb_out_valid,
    input  logic                 rb_out_ready,
    output logic [RB_AWIDTH:0]   rb_occupancy,
    output logic                 rb_overflow_err
);
    localparam int              PW       = RB_AWIDTH + 1;
    localparam int              CW       = $clog2(SIZE_FIFO_DEPTH) + 1;
    localparam logic [PW-1:0]   DEPTH    = {1'b1, {RB_AWIDTH{1'b0}}};
    localparam logic [31:0]     AF_LIM   = AF_SLACK;
    localparam logic [CW-1:0]   SZ_DEPTH = CW'(SIZE_FIFO_DEPTH);

    flit_lite_t           mem [2**RB_AWIDTH];
    flit_lite_t           ram_q;
    logic [PW-1:0]        tail_q, head_q, rd_ptr_q;
    logic [PW-1:0]        occ_q, free_q, tail_d, head_d, free_d;
    rb_state_t            state_q;
    logic [RB_AWIDTH-1:0] rem_q;
    logic                 sop_pend_q, rd_vld_q, rd_sop_q, rd_eop_q;
    logic                 af_q, err_q;
    rb_ent_t              ob0_q, ob1_q, ram_ent, head_ent, in1;
    logic [1:0]           ob_cnt_q, avail;

    logic                 commit_ok, commit_bad, pop_out, space, rd_issue, last_rd;
    logic                 sz_pop, sz_full, sz_empty, af_d;
    logic [RB_AWIDTH-1:0] sz_head;
    logic [CW-1:0]        sz_cnt, sz_cnt_nx, sz_free_d;

    unified_fifo #(
        .BITS_PER_SYMBOL(RB_AWIDTH),
        .FIFO_DEPTH     (SIZE_FIFO_DEPTH),
        .DUAL_CLOCK     (0)
    ) u_size_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .wr_en_i  (commit_ok),
        .wr_data_i(pcie_rb_update_size),
        .rd_en_i  (sz_pop),
        .rd_data_o(sz_head),
        .full_o   (sz_full),
        .empty_o  (sz_empty),
        .count_o  (sz_cnt)
    );

    // Overflow check uses pre-acceptance occupancy (conservative).
    assign occ_q      = tail_q - head_q;
    assign free_q     = DEPTH - occ_q;
    assign commit_ok  = pcie_rb_update_valid && (pcie_rb_update_size != '0) && !sz_full
                        && ({1'b0, pcie_rb_update_size} <= free_q);
    assign commit_bad = pcie_rb_update_valid && (pcie_rb_update_size != '0) && !commit_ok;

    // RAM output register acts as a third skid slot and falls through when the buffer is empty.
    assign ram_ent  = '{flit: ram_q, sop: rd_sop_q, eop: rd_eop_q};
    assign head_ent = (ob_cnt_q != 2'd0) ? ob0_q : ram_ent;
    assign in1      = (ob_cnt_q == 2'd2) ? ob1_q : ram_ent;
    assign avail    = ob_cnt_q + {1'b0, rd_vld_q};
    assign pop_out  = (avail != 2'd0) && rb_out_ready;
    assign space    = (avail - {1'b0, pop_out}) < 2'd2;
    assign rd_issue = (state_q == RB_STREAM) && space;
    assign last_rd  = rd_issue && (rem_q == RB_AWIDTH'(1));
    assign sz_pop   = !sz_empty && ((state_q == RB_IDLE) || last_rd);

    assign tail_d    = tail_q + (commit_ok ? {1'b0, pcie_rb_update_size} : '0);
    assign head_d    = head_q + PW'(pop_out);
    assign free_d    = DEPTH - (tail_d - head_d);
    assign sz_cnt_nx = sz_cnt + CW'(commit_ok) - CW'(sz_pop);
    assign sz_free_d = SZ_DEPTH - sz_cnt_nx;
    assign af_d      = ({{(32 - PW){1'b0}}, free_d} <= AF_LIM) || (sz_free_d <= CW'(2));

    always_ff @(posedge Clk) begin
        if (pcie_rb_wr_en)
            mem[pcie_rb_wr_addr] <= pcie_rb_wr_data;
        if (rd_issue)
            ram_q <= mem[rd_ptr_q[RB_AWIDTH-1:0]];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tail_q   <= '0;
            head_q   <= '0;
            rd_ptr_q <= '0;
            af_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_sop_q <= 1'b0;
            rd_eop_q <= 1'b0;
            ob0_q    <= '0;
            ob1_q    <= '0;
            ob_cnt_q <= '0;
        end else begin
            tail_q   <= tail_d;
            head_q   <= head_d;
            rd_ptr_q <= rd_ptr_q + PW'(rd_issue);
            af_q     <= af_d;
            err_q    <= err_q | commit_bad;
            rd_vld_q <= rd_issue;
            if (rd_issue) begin
                rd_sop_q <= sop_pend_q;
                rd_eop_q <= last_rd;
            end
            ob0_q    <= pop_out ? in1 : head_ent;
            ob1_q    <= in1;
            ob_cnt_q <= avail - {1'b0, pop_out};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= RB_IDLE;
            rem_q      <= '0;
            sop_pend_q <= 1'b0;
        end else begin
            case (state_q)
                RB_IDLE: begin
                    if (sz_pop) begin
                        rem_q      <= sz_head;
                        sop_pend_q <= 1'b1;
                        state_q    <= RB_STREAM;
                    end
                end
                RB_STREAM: begin
                    if (rd_issue) begin
                        rem_q      <= rem_q - 1'b1;
                        sop_pend_q <= 1'b0;
                        // Chain straight into the next block so boundaries cost no bubble.
                        if (last_rd) begin
                            if (sz_pop) begin
                                rem_q      <= sz_head;
                                sop_pend_q <= 1'b1;
                            end else begin
                                state_q <= RB_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= RB_IDLE;
            endcase
        end
    end

    assign pcie_rb_wr_base_addr = tail_q[RB_AWIDTH-1:0];
    assign pcie_rb_almost_full  = af_q;
    assign rb_occupancy         = occ_q;
    assign rb_overflow_err      = err_q;
    assign rb_out_valid         = (avail != 2'd0);
    assign rb_out_data          = head_ent.flit;
    assign rb_out_sop           = rb_out_valid && head_ent.sop;
    assign rb_out_eop           = rb_out_valid && head_ent.eop;

endmodule

// File: tb/tb_pcie_ring_buffer.sv
// Directed bench for pcie_ring_buffer with a flit scoreboard fed at commit time
// and drained by an output monitor.
module tb_pcie_ring_buffer;
    import pcie_ring_buffer_pkg::*;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b0;
    flit_lite_t     wr_data = '0;
    logic [AW-1:0]  wr_addr = '0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  base_addr;
    logic           almost_full;
    logic           upd_valid = 1'b0;
    logic [AW-1:0]  upd_size = '0;
    flit_lite_t     out_data;
    logic           out_sop, out_eop, out_valid;
    logic           out_ready = 1'b0;
    logic [AW:0]    occupancy;
    logic           overflow_err;

    pcie_ring_buffer #(
        .RB_AWIDTH      (AW),
        .AF_SLACK       (8),
        .SIZE_FIFO_DEPTH(8)
    ) dut (
        .Clk                 (Clk),
        .Rst_n               (Rst_n),
        .pcie_rb_wr_data     (wr_data),
        .pcie_rb_wr_addr     (wr_addr),
        .pcie_rb_wr_en       (wr_en),
        .pcie_rb_wr_base_addr(base_addr),
        .pcie_rb_almost_full (almost_full),
        .pcie_rb_update_valid(upd_valid),
        .pcie_rb_update_size (upd_size),
        .rb_out_data         (out_data),
        .rb_out_sop          (out_sop),
        .rb_out_eop          (out_eop),
        .rb_out_valid        (out_valid),
        .rb_out_ready        (out_ready),
        .rb_occupancy        (occupancy),
        .rb_overflow_err     (overflow_err)
    );

    always #5 Clk = ~Clk;

    rb_ent_t     sb[$];
    flit_lite_t  mem_m [DEPTH];
    int          mtail = 0, mhead = 0;
    int          checks = 0, errors = 0;
    int          n_sop = 0, n_eop = 0, n_acc = 0;
    logic        exp_err = 1'b0;
    logic        stall_q = 1'b0;
    rb_ent_t     stall_ent;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_lite_t mk(input int i);
        mk = '{tag: 4'(i), data: 32'hA500_0000 + 32'(i)};
    endfunction

    // Output monitor: pops the scoreboard on every accepted flit.
    always @(negedge Clk) begin
        rb_ent_t e;
        if (!Rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_data, out_sop, out_eop}), 64'(stall_ent));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_flit", 64'({out_data, out_sop, out_eop}), 64'(e));
                end
                n_sop += int'(out_sop);
                n_eop += int'(out_eop);
                n_acc++;
                mhead++;
            end
            stall_q   = out_valid && !out_ready;
            stall_ent = '{flit: out_data, sop: out_sop, eop: out_eop};
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int addr, input flit_lite_t d);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = d;
        mem_m[addr % DEPTH] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit(input int size);
        int occ;
        occ = mtail - mhead;
        upd_valid = 1'b1;
        upd_size  = AW'(size);
        if (size != 0 && size <= DEPTH - occ) begin
            for (int i = 0; i < size; i++)
                sb.push_back('{flit: mem_m[(mtail + i) % DEPTH], sop: (i == 0), eop: (i == size - 1)});
            mtail += size;
        end else if (size != 0) begin
            exp_err = 1'b1;
        end
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        check("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_base"}, 64'(base_addr), 64'd0);
        check({tag, "_af"}, 64'(almost_full), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sop"}, 64'(out_sop), 64'd0);
        check({tag, "_eop"}, 64'(out_eop), 64'd0);
        check({tag, "_occ"}, 64'(occupancy), 64'd0);
        check({tag, "_err"}, 64'(overflow_err), 64'd0);
    endtask

    initial begin
        #2;
        check_idle("rst");
        repeat (3) tick();
        Rst_n = 1'b1;
        tick();

        // Single block, latency T+3.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr(i, mk(i));
        commit(4);
        check("single_base", 64'(base_addr), 64'd4);
        check("single_occ", 64'(occupancy), 64'd4);
        check("single_af", 64'(almost_full), 64'd0);
        @(negedge Clk); check("lat_t1", 64'(out_valid), 64'd0);
        @(negedge Clk); check("lat_t2", 64'(out_valid), 64'd0);
        @(negedge Clk); check("lat_t3", 64'(out_valid), 64'd1);
        drain(20);
        check("single_occ_end", 64'(occupancy), 64'd0);

        // Zero-size commit is a no-op.
        commit(0);
        check("zero_base", 64'(base_addr), 64'd4);
        check("zero_err", 64'(overflow_err), 64'd0);
        check("zero_occ", 64'(occupancy), 64'd0);

        // Two back-to-back blocks under toggling ready.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) wr(4 + i, mk(16 + i));
        n_sop = 0; n_eop = 0; n_acc = 0;
        commit(5);
        commit(5);
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        drain(40);
        check("bp_count", 64'(n_acc), 64'd10);
        check("bp_sop", 64'(n_sop), 64'd2);
        check("bp_eop", 64'(n_eop), 64'd2);
        check("bp_base", 64'(base_addr), 64'd14);

        // Advance tail to 62, then a block that wraps the ring.
        for (int i = 0; i < 48; i++) wr(14 + i, mk(40 + i));
        commit(48);
        drain(100);
        wr(62, mk(100)); wr(63, mk(101)); wr(0, mk(102)); wr(1, mk(103));
        commit(4);
        check("wrap_base", 64'(base_addr), 64'd2);
        check("wrap_occ", 64'(occupancy), 64'd4);
        drain(20);
        check("wrap_occ_end", 64'(occupancy), 64'd0);

        // Almost-full asserts at 8 free, clears after one acceptance.
        out_ready = 1'b0;
        for (int i = 0; i < 56; i++) wr(2 + i, mk(200 + i));
        commit(56);
        check("af_set", 64'(almost_full), 64'd1);
        check("af_occ", 64'(occupancy), 64'd56);
        repeat (5) tick();
        check("af_valid", 64'(out_valid), 64'd1);
        check("af_still", 64'(almost_full), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("af_clr", 64'(almost_full), 64'd0);
        check("af_occ55", 64'(occupancy), 64'd55);

        // Fill to 60/64, then an oversize commit must be dropped.
        for (int i = 0; i < 5; i++) wr(58 + i, mk(300 + i));
        commit(5);
        check("ovf_occ60", 64'(occupancy), 64'd60);
        check("ovf_err0", 64'(overflow_err), 64'd0);
        commit(5);
        check("ovf_err", 64'(overflow_err), 64'(exp_err));
        check("ovf_base", 64'(base_addr), 64'd63);
        check("ovf_occ", 64'(occupancy), 64'd60);
        drain(200);
        check("ovf_sticky", 64'(overflow_err), 64'd1);
        check("ovf_occ_end", 64'(occupancy), 64'd0);
        check("ovf_af_end", 64'(almost_full), 64'd0);

        // Asynchronous reset in the middle of a block.
        for (int i = 0; i < 8; i++) wr(63 + i, mk(400 + i));
        commit(8);
        out_ready = 1'b1;
        repeat (3) tick();
        #1 Rst_n = 1'b0;
        #1 check_idle("async_rst");
        out_ready = 1'b0;
        sb.delete();
        mtail = 0; mhead = 0; exp_err = 1'b0;
        repeat (2) tick();
        Rst_n = 1'b1;
        tick();
        check_idle("post_rst");
        wr(0, mk(500)); wr(1, mk(501));
        commit(2);
        check("post_base", 64'(base_addr), 64'd2);
        drain(20);
        check("post_occ", 64'(occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
